deco_registros_salida: RTL and testbench
========================================

DECO_REGISTROS_SALIDA -- requirements
Module: deco_registros_salida

Interface
REQ-001 SHALL have parameter P_ID_DIRECCION, default 8'h01, port_id that selects the address register.
REQ-002 SHALL have parameter P_ID_DATO, default 8'h02, port_id that selects the data register.
REQ-003 SHALL have parameter P_ID_INICIO, default 8'h03, port_id that selects the init-start flag.
REQ-004 SHALL have parameter P_ID_LEER, default 8'h04, port_id that selects the read-start flag.
REQ-005 SHALL have parameter P_ID_ESCRIBIR, default 8'h05, port_id that selects the write-start flag.
REQ-006 clk  input  1  single system clock; all state updates on its rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-low.
REQ-008 port_id  input  8  processor output-port address.
REQ-009 W_Strobe  input  1  processor write strobe; write valid while high.
REQ-010 port_out  input  8  processor output data.
REQ-011 listo  input  1  done pulse from the RTC bus controller.
REQ-012 direccion  output  8  registered RTC register address.
REQ-013 dato  output  8  registered RTC write data.
REQ-014 arranque_inicio  output  1  registered start request, init sequence.
REQ-015 arranque_leer  output  1  registered start request, read sequence.
REQ-016 arranque_escribir  output  1  registered start request, write sequence.

Function
REQ-017 Write cycle = rising clk edge with W_Strobe=1; port_id and port_out are sampled at that edge.
REQ-018 Write with port_id==P_ID_DIRECCION SHALL load direccion<=port_out; visible the cycle after the edge.
REQ-019 Write with port_id==P_ID_DATO SHALL load dato<=port_out; visible the cycle after the edge.
REQ-020 direccion and dato SHALL hold their value in all other cycles, including while listo=1.
REQ-021 Write to a start-flag ID with port_out[0]=1 SHALL set that flag and clear the other two, so at most one arranque_* is high.
REQ-022 Write to a start-flag ID with port_out[0]=0 SHALL clear that flag only; port_out[7:1] is ignored.
REQ-023 listo=1 at a rising edge SHALL clear all three arranque_* flags, taking priority over a simultaneous start-flag write.
REQ-024 A simultaneous write to P_ID_DIRECCION or P_ID_DATO with listo=1 SHALL still load that register.
REQ-025 Writes with unmatched port_id, or with W_Strobe=0, SHALL change nothing.
REQ-026 A strobe held for several cycles SHALL re-write the same value each cycle with no side effects, making writes idempotent.
REQ-027 All outputs SHALL be driven directly from flops, with no combinational path from any input to any output.

Reset
REQ-028 rst=0 SHALL asynchronously force direccion=8'h00, dato=8'h00 and all arranque_*=0.
REQ-029 While rst=0, all writes and listo SHALL be ignored; normal operation resumes on the first rising edge after rst returns to 1.
REQ-030 Reset asserted mid-operation, with a flag high, SHALL clear that flag immediately without waiting for listo.

Structure
REQ-031 The five port-ID constants and the 8-bit data width SHALL live in the shared package deco_salida_pkg; the module parameters default to those constants.
REQ-032 The 8-bit enable-loadable register with asynchronous active-low clear SHALL be the sub-module reg_carga_8b, instantiated for direccion and dato; the start flags SHALL be coded in the top module.

Verification
REQ-033 Reset: rst=0 -> all outputs 0; after rst=1 with no strobe, outputs stay 0.
REQ-034 Address/data load: port_id=2, port_out=12, strobe 5 cycles -> dato=12; then port_id=1, port_out=4, strobe -> direccion=4 and dato remains 12.
REQ-035 Flag exclusivity: write 1 to ID 4 -> arranque_leer=1; write 1 to ID 3 -> arranque_inicio=1, arranque_leer=0; write 1 to ID 5 -> only arranque_escribir=1.
REQ-036 Completion: with arranque_escribir=1, listo=1 for 1 cycle -> all flags 0 next cycle; direccion=4 and dato=12 unchanged.
REQ-037 Collision: write 1 to ID 3 in the same cycle as listo=1 -> arranque_inicio stays 0; port_id=9 write -> no output changes.
REQ-038 Asynchronous reset: flag high and registers loaded, rst=0 between clock edges -> all outputs 0 before the next edge.

Source files
------------

// File: rtl/deco_salida_pkg.sv
// Shared constants and types for the processor output-port decoder.
// Port IDs here are the defaults used by the decoder module parameters.
package deco_salida_pkg;

  localparam int DATA_W = 8;

  localparam logic [DATA_W-1:0] ID_DIRECCION = 8'h01;
  localparam logic [DATA_W-1:0] ID_DATO      = 8'h02;
  localparam logic [DATA_W-1:0] ID_INICIO    = 8'h03;
  localparam logic [DATA_W-1:0] ID_LEER      = 8'h04;
  localparam logic [DATA_W-1:0] ID_ESCRIBIR  = 8'h05;

  // Start requests towards the RTC bus controller.
  typedef struct packed {
    logic inicio;
    logic leer;
    logic escribir;
  } arranque_t;

endpackage

// File: rtl/reg_carga_8b.sv
// Enable-loadable 8-bit register with asynchronous active-low clear.
module reg_carga_8b
  import deco_salida_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/deco_registros_salida.sv
// Decodes processor output-port writes into RTC address/data registers and
// mutually exclusive start requests that are cleared by the controller's done pulse.
module deco_registros_salida
  import deco_salida_pkg::*;
#(
  parameter logic [DATA_W-1:0] P_ID_DIRECCION = ID_DIRECCION,
  parameter logic [DATA_W-1:0] P_ID_DATO      = ID_DATO,
  parameter logic [DATA_W-1:0] P_ID_INICIO    = ID_INICIO,
  parameter logic [DATA_W-1:0] P_ID_LEER      = ID_LEER,
  parameter logic [DATA_W-1:0] P_ID_ESCRIBIR  = ID_ESCRIBIR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] port_id,
  input  logic              W_Strobe,
  input  logic [DATA_W-1:0] port_out,
  input  logic              listo,
  output logic [DATA_W-1:0] direccion,
  output logic [DATA_W-1:0] dato,
  output logic              arranque_inicio,
  output logic              arranque_leer,
  output logic              arranque_escribir
);

  logic      carga_direccion;
  logic      carga_dato;
  arranque_t flags;
  arranque_t flags_next;

  // listo does not gate these loads: a register write in the done cycle still lands.
  assign carga_direccion = W_Strobe && (port_id == P_ID_DIRECCION);
  assign carga_dato      = W_Strobe && (port_id == P_ID_DATO);

  reg_carga_8b u_reg_direccion (
    .clk   (clk),
    .rst_n (rst),
    .en    (carga_direccion),
    .d     (port_out),
    .q     (direccion)
  );

  reg_carga_8b u_reg_dato (
    .clk   (clk),
    .rst_n (rst),
    .en    (carga_dato),
    .d     (port_out),
    .q     (dato)
  );

  // NOTE: flags_next gets a full default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    flags_next = flags;
    if (listo) begin
      flags_next = '0;
    end else if (W_Strobe) begin
      // Setting one request drops the other two; clearing touches only its own.
      if (port_id == P_ID_INICIO) begin
        if (port_out[0]) begin
          flags_next        = '0;
          flags_next.inicio = 1'b1;
        end else begin
          flags_next.inicio = 1'b0;
        end
      end else if (port_id == P_ID_LEER) begin
        if (port_out[0]) begin
          flags_next      = '0;
          flags_next.leer = 1'b1;
        end else begin
          flags_next.leer = 1'b0;
        end
      end else if (port_id == P_ID_ESCRIBIR) begin
        if (port_out[0]) begin
          flags_next          = '0;
          flags_next.escribir = 1'b1;
        end else begin
          flags_next.escribir = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flags <= '0;
    end else begin
      flags <= flags_next;
    end
  end

  assign arranque_inicio   = flags.inicio;
  assign arranque_leer     = flags.leer;
  assign arranque_escribir = flags.escribir;

endmodule

// File: tb/tb_deco_registros_salida.sv
// Self-checking bench for deco_registros_salida: table-driven write vectors
// with a scoreboard queue, plus hand-written reset sequences.
module tb_deco_registros_salida;
  import deco_salida_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DATA_W-1:0] port_id = '0;
  logic              W_Strobe = 1'b0;
  logic [DATA_W-1:0] port_out = '0;
  logic              listo = 1'b0;
  logic [DATA_W-1:0] direccion;
  logic [DATA_W-1:0] dato;
  logic              arranque_inicio;
  logic              arranque_leer;
  logic              arranque_escribir;

  deco_registros_salida dut (
    .clk               (clk),
    .rst               (rst),
    .port_id           (port_id),
    .W_Strobe          (W_Strobe),
    .port_out          (port_out),
    .listo             (listo),
    .direccion         (direccion),
    .dato              (dato),
    .arranque_inicio   (arranque_inicio),
    .arranque_leer     (arranque_leer),
    .arranque_escribir (arranque_escribir)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] direccion;
    logic [7:0] dato;
    logic       inicio;
    logic       leer;
    logic       escribir;
  } out_t;

  typedef struct {
    logic       ws;
    logic [7:0] id;
    logic [7:0] data;
    logic       listo;
    out_t       exp;
  } vec_t;

  localparam int N_VEC = 22;
  vec_t vecs [N_VEC];
  out_t sb_q [$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic out_t mk_out(input logic [7:0] d, input logic [7:0] t,
                                  input logic i, input logic l, input logic e);
    out_t o;
    o.direccion = d;
    o.dato      = t;
    o.inicio    = i;
    o.leer      = l;
    o.escribir  = e;
    return o;
  endfunction

  function automatic vec_t mk_vec(input logic ws, input logic [7:0] id, input logic [7:0] data,
                                  input logic li, input out_t exp);
    vec_t v;
    v.ws    = ws;
    v.id    = id;
    v.data  = data;
    v.listo = li;
    v.exp   = exp;
    return v;
  endfunction

  task automatic check(input string name);
    out_t exp;
    out_t act;
    n_cmp++;
    if (sb_q.size() == 0) begin
      n_bad++;
      $display("FAIL %s: no expected value queued", name);
      return;
    end
    exp = sb_q.pop_front();
    act = mk_out(direccion, dato, arranque_inicio, arranque_leer, arranque_escribir);
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got dir=%h dato=%h ini/leer/esc=%b%b%b, want dir=%h dato=%h ini/leer/esc=%b%b%b",
               name, act.direccion, act.dato, act.inicio, act.leer, act.escribir,
               exp.direccion, exp.dato, exp.inicio, exp.leer, exp.escribir);
    end
  endtask

  task automatic drive(input logic ws, input logic [7:0] id, input logic [7:0] data,
                       input logic li);
    @(negedge clk);
    W_Strobe = ws;
    port_id  = id;
    port_out = data;
    listo    = li;
  endtask

  initial begin
    // Reset, idle, five-cycle data strobe, then address load.
    vecs[0]  = mk_vec(1'b0, 8'h00, 8'h00, 1'b0, mk_out(8'h00, 8'h00, 1'b0, 1'b0, 1'b0));
    for (int i = 1; i <= 5; i++)
      vecs[i] = mk_vec(1'b1, 8'h02, 8'd12, 1'b0, mk_out(8'h00, 8'h0C, 1'b0, 1'b0, 1'b0));
    vecs[6]  = mk_vec(1'b1, 8'h01, 8'd4,  1'b0, mk_out(8'h04, 8'h0C, 1'b0, 1'b0, 1'b0));
    vecs[7]  = mk_vec(1'b0, 8'h01, 8'h99, 1'b0, mk_out(8'h04, 8'h0C, 1'b0, 1'b0, 1'b0));
    // Flag exclusivity.
    vecs[8]  = mk_vec(1'b1, 8'h04, 8'h01, 1'b0, mk_out(8'h04, 8'h0C, 1'b0, 1'b1, 1'b0));
    vecs[9]  = mk_vec(1'b1, 8'h03, 8'h01, 1'b0, mk_out(8'h04, 8'h0C, 1'b1, 1'b0, 1'b0));
    vecs[10] = mk_vec(1'b1, 8'h05, 8'hFF, 1'b0, mk_out(8'h04, 8'h0C, 1'b0, 1'b0, 1'b1));
    // Completion, collision with listo, unmatched ID.
    vecs[11] = mk_vec(1'b0, 8'h00, 8'h00, 1'b1, mk_out(8'h04, 8'h0C, 1'b0, 1'b0, 1'b0));
    vecs[12] = mk_vec(1'b1, 8'h03, 8'h01, 1'b1, mk_out(8'h04, 8'h0C, 1'b0, 1'b0, 1'b0));
    vecs[13] = mk_vec(1'b1, 8'h09, 8'hFF, 1'b0, mk_out(8'h04, 8'h0C, 1'b0, 1'b0, 1'b0));
    // Clearing a flag with bit0=0 ignores upper bits and leaves other flags.
    vecs[14] = mk_vec(1'b1, 8'h04, 8'hFF, 1'b0, mk_out(8'h04, 8'h0C, 1'b0, 1'b1, 1'b0));
    vecs[15] = mk_vec(1'b1, 8'h04, 8'hFE, 1'b0, mk_out(8'h04, 8'h0C, 1'b0, 1'b0, 1'b0));
    vecs[16] = mk_vec(1'b1, 8'h05, 8'h01, 1'b0, mk_out(8'h04, 8'h0C, 1'b0, 1'b0, 1'b1));
    vecs[17] = mk_vec(1'b1, 8'h03, 8'h00, 1'b0, mk_out(8'h04, 8'h0C, 1'b0, 1'b0, 1'b1));
    vecs[18] = mk_vec(1'b0, 8'h01, 8'hAA, 1'b0, mk_out(8'h04, 8'h0C, 1'b0, 1'b0, 1'b1));
    // Register load still lands while listo clears the flag.
    vecs[19] = mk_vec(1'b1, 8'h01, 8'h55, 1'b1, mk_out(8'h55, 8'h0C, 1'b0, 1'b0, 1'b0));
    vecs[20] = mk_vec(1'b1, 8'h02, 8'hA5, 1'b0, mk_out(8'h55, 8'hA5, 1'b0, 1'b0, 1'b0));
    vecs[21] = mk_vec(1'b1, 8'h03, 8'h01, 1'b0, mk_out(8'h55, 8'hA5, 1'b1, 1'b0, 1'b0));

    // Power-on reset, asserted before any clock edge.
    #2 rst = 1'b0;
    #1;
    sb_q.push_back(mk_out(8'h00, 8'h00, 1'b0, 1'b0, 1'b0));
    check("reset_async_start");
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      sb_q.push_back(mk_out(8'h00, 8'h00, 1'b0, 1'b0, 1'b0));
      @(posedge clk);
      #1;
      check($sformatf("reset_idle%0d", i));
    end

    for (int i = 0; i < N_VEC; i++) begin
      drive(vecs[i].ws, vecs[i].id, vecs[i].data, vecs[i].listo);
      sb_q.push_back(vecs[i].exp);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i));
    end

    // Asynchronous reset mid-cycle with arranque_inicio high and registers loaded.
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    sb_q.push_back(mk_out(8'h00, 8'h00, 1'b0, 1'b0, 1'b0));
    check("reset_async_mid");

    drive(1'b1, 8'h01, 8'h77, 1'b0);
    sb_q.push_back(mk_out(8'h00, 8'h00, 1'b0, 1'b0, 1'b0));
    @(posedge clk);
    #1;
    check("write_during_reset");

    drive(1'b0, 8'h00, 8'h00, 1'b0);
    rst = 1'b1;
    sb_q.push_back(mk_out(8'h00, 8'h00, 1'b0, 1'b0, 1'b0));
    @(posedge clk);
    #1;
    check("post_reset_idle");

    drive(1'b1, 8'h02, 8'h3C, 1'b0);
    sb_q.push_back(mk_out(8'h00, 8'h3C, 1'b0, 1'b0, 1'b0));
    @(posedge clk);
    #1;
    check("resume_write");

    drive(1'b0, 8'h00, 8'h00, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
